// File: rtl/inliers_pkg.sv
// ============================================================================
// Module  : inliers_pkg
// Brief   : Register map, control/status bit positions and FSM encoding
//           shared by the RANSAC inlier accelerator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package inliers_pkg;

    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_LINE_A  = 1;
    localparam int ADDR_LINE_B  = 2;
    localparam int ADDR_THRESH  = 3;
    localparam int ADDR_POINT_X = 4;
    localparam int ADDR_POINT_Y = 5;
    localparam int ADDR_STATUS  = 6;
    localparam int ADDR_COUNT   = 7;
    localparam int ADDR_IRQ_EN  = 8;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_ACK   = 2;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_FULL   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_WR_ERR = 4;
    localparam int STAT_IRQ_EN = 5;
    localparam int STAT_NPTS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Product plus offset plus sign and one guard bit: never truncates.
    function automatic int residual_w(input int data_w);
        return 2 * data_w + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inliers_datapath.sv
// ============================================================================
// Module  : inliers_datapath
// Brief   : Two-stage multiply / residual / threshold compare with inlier
//           accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inliers_datapath
    import inliers_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_y,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic        [DATA_W-1:0] thresh,
    output logic                     s1_valid,
    output logic        [ACC_W-1:0]  acc
);

    localparam int RW = residual_w(DATA_W);

    logic signed [2*DATA_W-1:0] r_p;
    logic signed [DATA_W-1:0]   r_y1;
    logic                       r_v1;
    logic        [ACC_W-1:0]    r_acc;

    logic signed [RW-1:0] w_f;
    logic signed [RW-1:0] w_ys;
    logic signed [RW-1:0] w_diff;
    logic        [RW-1:0] w_r;
    logic                 w_inlier;

    always_comb begin
        w_f      = RW'(r_p) + RW'(b);
        w_ys     = RW'(r_y1) <<< FRAC_BITS;
        w_diff   = w_ys - w_f;
        w_r      = w_diff[RW-1] ? unsigned'(-w_diff) : unsigned'(w_diff);
        w_inlier = (w_r <= RW'(thresh));
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_v1  <= 1'b0;
            r_p   <= '0;
            r_y1  <= '0;
            r_acc <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_p  <= (2*DATA_W)'(a) * (2*DATA_W)'(in_x);
                r_y1 <= in_y;
            end
            if (r_v1 && w_inlier) begin
                r_acc <= r_acc + ACC_W'(1);
            end
        end
    end

    assign s1_valid = r_v1;
    assign acc      = r_acc;

endmodule

`default_nettype wire

// File: rtl/inliers_accel_mm.sv
// ============================================================================
// Module  : inliers_accel_mm
// Brief   : Avalon-MM RANSAC inlier counter with resident point buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inliers_accel_mm
    import inliers_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 8,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int NPTS_W = $clog2(DEPTH + 1);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_W-1:0] r_line_a, r_line_b, r_sh_a, r_sh_b;
    logic        [DATA_W-1:0] r_thresh, r_sh_t, r_px;
    logic        [NPTS_W-1:0] r_npts, r_idx, r_count;
    logic                     r_ovf, r_wr_err, r_irq_en, r_s0_valid;
    logic [2*DATA_W-1:0]      r_rd;
    logic [2*DATA_W-1:0]      r_mem [DEPTH];

    logic w_cmd_start, w_cmd_clear, w_cmd_ack, w_push, w_mem_we;
    logic w_busy, w_done, w_full, w_issue, w_drained, w_last_issue;
    logic w_start_run, w_start_empty, w_finish, w_s1_valid;
    logic [NPTS_W-1:0] w_acc;

    // Write decode
    always_comb begin
        w_cmd_start = write && (address == ADDR_W'(ADDR_CTRL)) && writedata[CTRL_START];
        w_cmd_clear = write && (address == ADDR_W'(ADDR_CTRL)) && writedata[CTRL_CLEAR];
        w_cmd_ack   = write && (address == ADDR_W'(ADDR_CTRL)) && writedata[CTRL_ACK];
        w_push      = write && (address == ADDR_W'(ADDR_POINT_Y));
        w_full      = (r_npts == NPTS_W'(DEPTH));
        w_mem_we    = w_push && !w_busy && !w_full;
        w_last_issue = (r_idx == r_npts - NPTS_W'(1));
        w_drained   = !r_s0_valid && !w_s1_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd_clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_start) w_state_nxt = (r_npts == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (w_last_issue) w_state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_drained) w_state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (w_cmd_start)    w_state_nxt = (r_npts == '0) ? ST_DONE : ST_RUN;
                    else if (w_cmd_ack) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        w_done        = (r_state == ST_DONE);
        w_issue       = (r_state == ST_RUN);
        w_start_run   = !w_busy && w_cmd_start && !w_cmd_clear && (r_npts != '0);
        w_start_empty = !w_busy && w_cmd_start && !w_cmd_clear && (r_npts == '0);
        w_finish      = (r_state == ST_DRAIN) && w_drained && !w_cmd_clear;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_line_a <= '0;
            r_line_b <= '0;
            r_thresh <= '0;
            r_px     <= '0;
            r_irq_en <= 1'b0;
            r_npts   <= '0;
            r_ovf    <= 1'b0;
            r_wr_err <= 1'b0;
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_sh_t   <= '0;
        end else begin
            if (write && address == ADDR_W'(ADDR_LINE_A))  r_line_a <= writedata[DATA_W-1:0];
            if (write && address == ADDR_W'(ADDR_LINE_B))  r_line_b <= writedata[DATA_W-1:0];
            if (write && address == ADDR_W'(ADDR_THRESH))  r_thresh <= writedata[DATA_W-1:0];
            if (write && address == ADDR_W'(ADDR_POINT_X)) r_px     <= writedata[DATA_W-1:0];
            if (write && address == ADDR_W'(ADDR_IRQ_EN))  r_irq_en <= writedata[0];
            if (w_cmd_clear) begin
                r_npts   <= '0;
                r_ovf    <= 1'b0;
                r_wr_err <= 1'b0;
            end else if (w_push) begin
                if (w_busy)      r_wr_err <= 1'b1;
                else if (w_full) r_ovf    <= 1'b1;
                else             r_npts   <= r_npts + NPTS_W'(1);
            end
            // The run only ever sees these snapshots, so live register writes are safe.
            if (w_start_run) begin
                r_sh_a <= r_line_a;
                r_sh_b <= r_line_b;
                r_sh_t <= r_thresh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx      <= '0;
            r_s0_valid <= 1'b0;
            r_count    <= '0;
        end else begin
            r_s0_valid <= w_issue && !w_cmd_clear;
            if (w_start_run)  r_idx <= '0;
            else if (w_issue) r_idx <= r_idx + NPTS_W'(1);
            if (w_cmd_clear || w_start_empty) r_count <= '0;
            else if (w_finish)                r_count <= w_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_npts[IDX_W-1:0]] <= {r_px, writedata[DATA_W-1:0]};
        r_rd <= r_mem[r_idx[IDX_W-1:0]];
    end

    inliers_datapath #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (NPTS_W)
    ) u_datapath (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (w_cmd_clear || w_start_run),
        .in_valid (r_s0_valid),
        .in_x     (r_rd[2*DATA_W-1:DATA_W]),
        .in_y     (r_rd[DATA_W-1:0]),
        .a        (r_sh_a),
        .b        (r_sh_b),
        .thresh   (r_sh_t),
        .s1_valid (w_s1_valid),
        .acc      (w_acc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= '0;
            case (address)
                ADDR_W'(ADDR_LINE_A): readdata <= 32'(r_line_a);
                ADDR_W'(ADDR_LINE_B): readdata <= 32'(r_line_b);
                ADDR_W'(ADDR_THRESH): readdata <= 32'(r_thresh);
                ADDR_W'(ADDR_STATUS): begin
                    readdata[STAT_BUSY]   <= w_busy;
                    readdata[STAT_DONE]   <= w_done;
                    readdata[STAT_FULL]   <= w_full;
                    readdata[STAT_OVF]    <= r_ovf;
                    readdata[STAT_WR_ERR] <= r_wr_err;
                    readdata[STAT_IRQ_EN] <= r_irq_en;
                    readdata[31:STAT_NPTS] <= 16'(r_npts);
                end
                ADDR_W'(ADDR_COUNT):  readdata <= 32'(r_count);
                ADDR_W'(ADDR_IRQ_EN): readdata <= {31'd0, r_irq_en};
                default:              readdata <= '0;
            endcase
        end
    end

    assign irq = w_done && r_irq_en;

endmodule

`default_nettype wire
